pulse_input_qualifier: RTL and testbench
========================================

// Module: pulse_input_qualifier
// PURPOSE
// Front-end stage that consumes the raw trigger pulse stream (e.g. random or periodic test pulses) feeding a delay channel.
// Synchronizes the asynchronous pulse input and timestamps each rising edge with a free-running cycle counter.
// Measures pulse width, and rejects glitches and pulses that violate a minimum edge-to-edge spacing (dead time).
// Queues qualified pulse records in a small FIFO with a valid/ready handshake for the downstream delay/readout logic.
// PARAMETERS
// g_sync_stages  2    synchronizer flops on pulse_i (>=2)
// g_min_width    2    min accepted high time, clk cycles (>=1)
// g_min_spacing  16   min rising-to-rising spacing, clk cycles (>=1)
// g_cnt_width    32   timestamp counter width (>=8)
// g_fifo_depth   4    record FIFO depth; power of 2, >=2
// PORTS
// clk_sys_i     in   1            system clock; all logic on rising edge
// rst_n_i       in   1            synchronous reset, active low
// enable_i      in   1            qualifier enable
// pulse_i       in   1            asynchronous pulse input
// rec_valid_o   out  1            FIFO head record valid
// rec_ready_i   in   1            downstream accepts head record
// rec_ts_o      out  g_cnt_width  timestamp of record's rising edge
// rec_width_o   out  16           record high time, cycles, saturating
// overflow_o    out  1            sticky: qualified pulse dropped, FIFO full
// clr_ovf_i     in   1            clears overflow_o
// reject_cnt_o  out  16           glitch + spacing-violation count, saturating
// BEHAVIOUR
// - Reset (rst_n_i=0 at clk edge): FSM=IDLE, FIFO empty, ts counter=0, armed=0, all outputs 0, sync flops 0.
// - pulse_s = last sync stage; rise = pulse_s & ~pulse_d. Pin-to-detect latency g_sync_stages+1 cycles, not compensated.
// - ts_cnt increments every cycle regardless of enable_i; wraps 2^g_cnt_width-1 -> 0.
// - armed: cleared by reset or enable_i=0; set in any cycle with pulse_s=0. Rises only count when armed=1,
//   so a pulse already high at reset release/enable is never recorded.
// - FSM IDLE: rise & enable_i & armed -> latch ts=ts_cnt, wcnt=1, scnt=1 -> HIGH.
// - HIGH: pulse_s=1 -> wcnt++ (sat 0xFFFF). pulse_s=0: wcnt>=g_min_width -> push {ts,wcnt}, -> DEAD;
//   else reject_cnt++, -> IDLE (no dead time after glitch). scnt++ every cycle from HIGH entry.
// - DEAD: scnt++ (sat); rise -> reject_cnt++, pulse ignored. Exit to IDLE when scnt>=g_min_spacing AND pulse_s=0.
// - enable_i=0: next cycle FSM=IDLE, in-flight pulse discarded (no record, no reject); FIFO and counters kept.
// - reject_cnt_o saturates at 0xFFFF; cleared only by reset.
// - FIFO: first-word-fall-through; rec_valid_o = not empty; pop when rec_valid_o & rec_ready_i.
//   Record on outputs the cycle after the falling edge is detected (if FIFO was empty).
// - Push when full: dropped, overflow_o=1 -- unless pop same cycle, then push accepted.
// - Simultaneous push+pop on empty/partial FIFO: both performed, count unchanged.
// - clr_ovf_i=1 clears overflow_o; same-cycle drop wins (overflow_o stays 1).
// - rec_ts_o/rec_width_o undefined-but-stable when rec_valid_o=0 (implementation drives 0 from empty FIFO is acceptable).
// - Reset mid-operation: all state discarded at that edge; no partial record emitted.
// TESTING
// 1. Defaults, ready=1; pulse_i high 4 cycles -> one record, rec_width_o=4, rec_ts_o=ts_cnt at rise detect; reject_cnt_o=0.
// 2. 1-cycle pulse_i high -> no record, reject_cnt_o=1; pulse 3 cycles later (width 4) -> accepted record.
// 3. Two 4-cycle pulses, rises 8 cycles apart -> first recorded, second rejected: reject_cnt_o=1; rises 16 apart -> both recorded.
// 4. ready=0, 6 pulses spaced 40 cycles -> 4 records queued, overflow_o=1; ready=1 -> pulses 1..4 in order; clr_ovf_i -> overflow_o=0.
// 5. rst_n_i=0 while pulse_i high -> next cycle all outputs 0; release with pulse_i still high -> no record until low then new rise.
// 6. g_cnt_width=8: rise detected at ts_cnt=255 -> rec_ts_o=255; next pulse 40 cycles later -> rec_ts_o=39 (wrapped).

Source files
------------

// File: rtl/pulse_input_qualifier.sv
// Pulse input qualifier: synchronizes a raw pulse, timestamps rises, rejects glitches and dead-time violations.
// Latency: rise seen g_sync_stages+1 cycles after the pin; record on rec_*_o one cycle after the fall is detected.
// Backpressure: rec_ready_i stalls the record FIFO; a qualified pulse arriving while full is dropped and flagged.

module pif_fifo #(
    parameter int g_width = 8,
    parameter int g_depth = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_wr_vld,
    output logic               o_wr_rdy,
    input  logic [g_width-1:0] i_wr_dat,
    output logic               o_rd_vld,
    input  logic               i_rd_rdy,
    output logic [g_width-1:0] o_rd_dat
);
    // First-word-fall-through FIFO; a write into a full FIFO is accepted when the head pops in the same cycle.
    localparam int              c_aw   = $clog2(g_depth);
    localparam logic [c_aw:0]   c_full = (c_aw + 1)'(g_depth);

    logic [g_width-1:0] r_mem [g_depth];
    logic [c_aw-1:0]    r_wptr;
    logic [c_aw-1:0]    r_rptr;
    logic [c_aw:0]      r_count;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;

    assign w_empty  = (r_count == '0);
    assign w_pop    = ~w_empty & i_rd_rdy;
    assign o_wr_rdy = (r_count != c_full) | w_pop;
    assign w_push   = i_wr_vld & o_wr_rdy;
    assign o_rd_vld = ~w_empty;
    assign o_rd_dat = w_empty ? '0 : r_mem[r_rptr];

    // Storage array; contents are only observable through the non-empty head, so no reset.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wr_dat;
        end
    end

    // Pointers and occupancy; push and pop in one cycle leave the count unchanged.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_aw'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_aw'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (c_aw + 1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (c_aw + 1)'(1);
            end
        end
    end
endmodule

module pulse_input_qualifier #(
    parameter int g_sync_stages = 2,
    parameter int g_min_width   = 2,
    parameter int g_min_spacing = 16,
    parameter int g_cnt_width   = 32,
    parameter int g_fifo_depth  = 4
) (
    input  logic                   clk_sys_i,
    input  logic                   rst_n_i,
    input  logic                   enable_i,
    input  logic                   pulse_i,
    output logic                   rec_valid_o,
    input  logic                   rec_ready_i,
    output logic [g_cnt_width-1:0] rec_ts_o,
    output logic [15:0]            rec_width_o,
    output logic                   overflow_o,
    input  logic                   clr_ovf_i,
    output logic [15:0]            reject_cnt_o
);
    typedef struct packed {
        logic [g_cnt_width-1:0] ts;
        logic [15:0]            width;
    } rec_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_DEAD = 2'd2
    } state_t;

    localparam int c_rec_w = $bits(rec_t);

    logic [g_sync_stages-1:0] r_sync;
    logic [g_sync_stages-1:0] r_fill;
    logic                     r_pulse_d;
    logic                     r_armed;
    logic [g_cnt_width-1:0]   r_ts_cnt;
    state_t                   r_state;
    logic [g_cnt_width-1:0]   r_ts_lat;
    logic [15:0]              r_wcnt;
    logic [15:0]              r_scnt;
    logic [15:0]              r_reject;
    logic                     r_ovf;

    state_t                   w_state_nxt;
    logic [g_cnt_width-1:0]   w_ts_nxt;
    logic [15:0]              w_wcnt_nxt;
    logic [15:0]              w_scnt_nxt;
    logic [15:0]              w_wcnt_inc;
    logic [15:0]              w_scnt_inc;
    logic                     w_pulse_s;
    logic                     w_sync_ok;
    logic                     w_rise;
    logic                     w_push;
    logic                     w_reject;
    logic                     w_fifo_wr_rdy;
    logic                     w_drop;
    rec_t                     w_rec_in;
    rec_t                     w_rec_head;

    // r_fill marks when the synchronizer output reflects a real pin sample rather than reset zeros,
    // so a pulse already high at reset release cannot arm the detector.
    assign w_pulse_s  = r_sync[g_sync_stages-1];
    assign w_sync_ok  = r_fill[g_sync_stages-1];
    assign w_rise     = w_pulse_s & ~r_pulse_d;
    assign w_wcnt_inc = (r_wcnt == 16'hFFFF) ? r_wcnt : r_wcnt + 16'd1;
    assign w_scnt_inc = (r_scnt == 16'hFFFF) ? r_scnt : r_scnt + 16'd1;

    // Pin synchronizer, fill tracker and one-cycle delayed copy for edge detection.
    always_ff @(posedge clk_sys_i) begin
        if (!rst_n_i) begin
            r_sync    <= '0;
            r_fill    <= '0;
            r_pulse_d <= 1'b0;
        end else begin
            r_sync    <= {r_sync[g_sync_stages-2:0], pulse_i};
            r_fill    <= {r_fill[g_sync_stages-2:0], 1'b1};
            r_pulse_d <= w_pulse_s;
        end
    end

    // Free-running timestamp counter and arming flag (re-armed whenever the input is seen low).
    always_ff @(posedge clk_sys_i) begin
        if (!rst_n_i) begin
            r_ts_cnt <= '0;
            r_armed  <= 1'b0;
        end else begin
            r_ts_cnt <= r_ts_cnt + g_cnt_width'(1);
            if (!enable_i) begin
                r_armed <= 1'b0;
            end else if (w_sync_ok && !w_pulse_s) begin
                r_armed <= 1'b1;
            end
        end
    end

    // Qualifier state register with latched timestamp, width and spacing counters.
    always_ff @(posedge clk_sys_i) begin
        if (!rst_n_i) begin
            r_state  <= S_IDLE;
            r_ts_lat <= '0;
            r_wcnt   <= '0;
            r_scnt   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ts_lat <= w_ts_nxt;
            r_wcnt   <= w_wcnt_nxt;
            r_scnt   <= w_scnt_nxt;
        end
    end

    // Next-state logic: width measurement in HIGH, dead time in DEAD; the spacing exit looks one
    // cycle ahead so a rise exactly g_min_spacing after the previous accepted rise lands in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_ts_nxt    = r_ts_lat;
        w_wcnt_nxt  = r_wcnt;
        w_scnt_nxt  = r_scnt;
        w_push      = 1'b0;
        w_reject    = 1'b0;
        if (!enable_i) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_rise && r_armed) begin
                        w_state_nxt = S_HIGH;
                        w_ts_nxt    = r_ts_cnt;
                        w_wcnt_nxt  = 16'd1;
                        w_scnt_nxt  = 16'd1;
                    end
                end
                S_HIGH: begin
                    w_scnt_nxt = w_scnt_inc;
                    if (w_pulse_s) begin
                        w_wcnt_nxt = w_wcnt_inc;
                    end else if (r_wcnt >= 16'(g_min_width)) begin
                        w_push      = 1'b1;
                        w_state_nxt = S_DEAD;
                    end else begin
                        w_reject    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_DEAD: begin
                    w_scnt_nxt = w_scnt_inc;
                    if (w_rise) begin
                        w_reject = 1'b1;
                    end
                    if ((w_scnt_inc >= 16'(g_min_spacing)) && !w_pulse_s) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign w_rec_in = '{ts: r_ts_lat, width: r_wcnt};
    assign w_drop   = w_push & ~w_fifo_wr_rdy;

    // Saturating reject counter and sticky overflow flag (a drop beats a same-cycle clear).
    always_ff @(posedge clk_sys_i) begin
        if (!rst_n_i) begin
            r_reject <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_reject && (r_reject != 16'hFFFF)) begin
                r_reject <= r_reject + 16'd1;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf_i) begin
                r_ovf <= 1'b0;
            end
        end
    end

    pif_fifo #(
        .g_width (c_rec_w),
        .g_depth (g_fifo_depth)
    ) u_rec_fifo (
        .i_clk    (clk_sys_i),
        .i_rst_n  (rst_n_i),
        .i_wr_vld (w_push),
        .o_wr_rdy (w_fifo_wr_rdy),
        .i_wr_dat (w_rec_in),
        .o_rd_vld (rec_valid_o),
        .i_rd_rdy (rec_ready_i),
        .o_rd_dat (w_rec_head)
    );

    assign rec_ts_o     = w_rec_head.ts;
    assign rec_width_o  = w_rec_head.width;
    assign overflow_o   = r_ovf;
    assign reject_cnt_o = r_reject;
endmodule

// File: tb/tb_pulse_input_qualifier.sv
// Bench for pulse_input_qualifier: directed scenarios plus a randomized pulse train.
// Expected records come from pulse-level rules (width and rise-to-rise spacing of the pin waveform).
// Inputs change 1 time unit after a rising edge; records are collected on the falling edge.
module tb_pulse_input_qualifier;
    localparam int S    = 2;
    localparam int MINW = 2;
    localparam int SP   = 16;
    localparam int CW   = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0, enable = 1'b1, pulse = 1'b0, rec_ready = 1'b1, clr_ovf = 1'b0;
    logic rec_valid, overflow;
    logic [CW-1:0] rec_ts;
    logic [15:0] rec_width, reject_cnt;
    logic pulse8 = 1'b0, ready8 = 1'b1;
    logic rec_valid8, overflow8;
    logic [7:0] rec_ts8;
    logic [15:0] rec_width8, reject8;

    pulse_input_qualifier dut (
        .clk_sys_i(clk), .rst_n_i(rst_n), .enable_i(enable), .pulse_i(pulse),
        .rec_valid_o(rec_valid), .rec_ready_i(rec_ready), .rec_ts_o(rec_ts),
        .rec_width_o(rec_width), .overflow_o(overflow), .clr_ovf_i(clr_ovf),
        .reject_cnt_o(reject_cnt)
    );

    pulse_input_qualifier #(.g_cnt_width(8)) dut8 (
        .clk_sys_i(clk), .rst_n_i(rst_n), .enable_i(1'b1), .pulse_i(pulse8),
        .rec_valid_o(rec_valid8), .rec_ready_i(ready8), .rec_ts_o(rec_ts8),
        .rec_width_o(rec_width8), .overflow_o(overflow8), .clr_ovf_i(1'b0),
        .reject_cnt_o(reject8)
    );

    int checks = 0, errors = 0;
    longint cyc = 0, e0 = 0, last_acc = -1000;
    int rej_exp = 0;
    bit rand_ready = 1'b0;
    longint exp_ts[$], obs_ts[$];
    int exp_w[$], obs_w[$], obs8_ts[$], tr_w[$], tr_g[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && rec_valid && rec_ready) begin
            obs_ts.push_back(longint'(rec_ts));
            obs_w.push_back(int'(rec_width));
        end
        if (rst_n && rec_valid8) obs8_ts.push_back(int'(rec_ts8));
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) rec_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic clear_q();
        exp_ts.delete(); exp_w.delete(); obs_ts.delete(); obs_w.delete(); obs8_ts.delete();
    endtask

    task automatic model_reset();
        last_acc = -1000;
        rej_exp  = 0;
        clear_q();
    endtask

    // Plays tr_g/tr_w (low gap, then high width) on the pin and predicts records from pulse-level rules.
    task automatic play_train(input int trail);
        for (int i = 0; i < tr_w.size(); i++) begin
            longint c;
            for (int g = 0; g < tr_g[i]; g++) begin step(); pulse = 1'b0; end
            step();
            pulse = 1'b1;
            c = cyc;
            if (c - last_acc < SP) rej_exp++;
            else if (tr_w[i] < MINW) rej_exp++;
            else begin
                exp_ts.push_back((c + S - e0) % (longint'(1) << CW));
                exp_w.push_back(tr_w[i]);
                last_acc = c;
            end
            for (int k = 1; k < tr_w[i]; k++) begin step(); pulse = 1'b1; end
        end
        for (int t = 0; t < trail; t++) begin step(); pulse = 1'b0; end
        tr_w.delete();
        tr_g.delete();
    endtask

    task automatic do_reset();
        step(); rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        e0 = cyc;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks += 6;
        if (rec_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0d expected 0", rec_valid); end
        if (rec_ts !== '0) begin errors++; $display("FAIL reset_ts: got %0d expected 0", rec_ts); end
        if (rec_width !== 16'd0) begin errors++; $display("FAIL reset_width: got %0d expected 0", rec_width); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0d expected 0", overflow); end
        if (reject_cnt !== 16'd0) begin errors++; $display("FAIL reset_reject: got %0d expected 0", reject_cnt); end
        if (rec_valid8 !== 1'b0) begin errors++; $display("FAIL reset_valid8: got %0d expected 0", rec_valid8); end
    endtask

    task automatic test_single_pulse();
        clear_q();
        tr_w = '{4}; tr_g = '{8};
        play_train(20);
        checks += 4;
        if (obs_ts.size() != 1) begin errors++; $display("FAIL single_count: got %0d expected 1", obs_ts.size()); end
        else begin
            if (obs_ts[0] != exp_ts[0]) begin errors++; $display("FAIL single_ts: got %0d expected %0d", obs_ts[0], exp_ts[0]); end
            if (obs_w[0] != 4) begin errors++; $display("FAIL single_width: got %0d expected 4", obs_w[0]); end
        end
        if (int'(reject_cnt) != rej_exp) begin errors++; $display("FAIL single_reject: got %0d expected %0d", reject_cnt, rej_exp); end
    endtask

    task automatic test_glitch();
        clear_q();
        tr_w = '{1, 4}; tr_g = '{25, 3};
        play_train(20);
        checks += 4;
        if (obs_ts.size() != 1) begin errors++; $display("FAIL glitch_count: got %0d expected 1", obs_ts.size()); end
        else begin
            if (obs_ts[0] != exp_ts[0]) begin errors++; $display("FAIL glitch_ts: got %0d expected %0d", obs_ts[0], exp_ts[0]); end
            if (obs_w[0] != 4) begin errors++; $display("FAIL glitch_width: got %0d expected 4", obs_w[0]); end
        end
        if (int'(reject_cnt) != rej_exp) begin errors++; $display("FAIL glitch_reject: got %0d expected %0d", reject_cnt, rej_exp); end
    endtask

    task automatic test_spacing();
        clear_q();
        tr_w = '{4, 4, 4, 4}; tr_g = '{25, 4, 30, 12};
        play_train(25);
        checks += 2;
        if (obs_ts.size() != 3 || exp_ts.size() != 3) begin
            errors++; $display("FAIL spacing_count: got %0d expected 3", obs_ts.size());
        end
        for (int i = 0; i < obs_ts.size() && i < exp_ts.size(); i++) begin
            checks++;
            if (obs_ts[i] != exp_ts[i] || obs_w[i] != exp_w[i]) begin
                errors++; $display("FAIL spacing_rec%0d: got ts %0d w %0d expected ts %0d w %0d", i, obs_ts[i], obs_w[i], exp_ts[i], exp_w[i]);
            end
        end
        if (int'(reject_cnt) != rej_exp) begin errors++; $display("FAIL spacing_reject: got %0d expected %0d", reject_cnt, rej_exp); end
    endtask

    task automatic test_overflow();
        clear_q();
        rec_ready = 1'b0;
        tr_w = '{4, 4, 4, 4, 4, 4}; tr_g = '{36, 36, 36, 36, 36, 36};
        play_train(20);
        checks += 3;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %0d expected 1", overflow); end
        if (rec_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid: got %0d expected 1", rec_valid); end
        if (obs_ts.size() != 0) begin errors++; $display("FAIL ovf_stalled: got %0d records expected 0", obs_ts.size()); end
        rec_ready = 1'b1;
        repeat (10) step();
        checks++;
        if (obs_ts.size() != 4) begin errors++; $display("FAIL ovf_drain_count: got %0d expected 4", obs_ts.size()); end
        for (int i = 0; i < obs_ts.size() && i < 4; i++) begin
            checks++;
            if (obs_ts[i] != exp_ts[i] || obs_w[i] != exp_w[i]) begin
                errors++; $display("FAIL ovf_rec%0d: got ts %0d w %0d expected ts %0d w %0d", i, obs_ts[i], obs_w[i], exp_ts[i], exp_w[i]);
            end
        end
        step(); clr_ovf = 1'b1;
        step(); clr_ovf = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %0d expected 0", overflow); end
    endtask

    task automatic test_enable_drop();
        clear_q();
        repeat (5) begin step(); pulse = 1'b0; end
        step(); pulse = 1'b1;
        repeat (3) step();
        step(); enable = 1'b0;
        step(); step(); pulse = 1'b0;
        repeat (5) step();
        enable = 1'b1;
        repeat (20) step();
        checks += 2;
        if (obs_ts.size() != 0) begin errors++; $display("FAIL enable_norec: got %0d expected 0", obs_ts.size()); end
        if (int'(reject_cnt) != rej_exp) begin errors++; $display("FAIL enable_reject: got %0d expected %0d", reject_cnt, rej_exp); end
        tr_w = '{5}; tr_g = '{20};
        play_train(20);
        checks++;
        if (obs_ts.size() != 1 || obs_ts[0] != exp_ts[0] || obs_w[0] != 5) begin
            errors++; $display("FAIL enable_rearm: got %0d records expected 1 with width 5", obs_ts.size());
        end
    endtask

    task automatic test_reset_mid();
        clear_q();
        rec_ready = 1'b0;
        tr_w = '{1, 4}; tr_g = '{20, 3};
        play_train(15);
        step(); pulse = 1'b1;
        repeat (3) step();
        rst_n = 1'b0;
        step();
        checks += 5;
        if (rec_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %0d expected 0", rec_valid); end
        if (rec_ts !== '0) begin errors++; $display("FAIL rstmid_ts: got %0d expected 0", rec_ts); end
        if (rec_width !== 16'd0) begin errors++; $display("FAIL rstmid_width: got %0d expected 0", rec_width); end
        if (reject_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_reject: got %0d expected 0", reject_cnt); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL rstmid_ovf: got %0d expected 0", overflow); end
        rst_n = 1'b1;
        e0 = cyc;
        model_reset();
        rec_ready = 1'b1;
        repeat (10) begin step(); pulse = 1'b1; end
        repeat (20) begin step(); pulse = 1'b0; end
        checks += 2;
        if (obs_ts.size() != 0) begin errors++; $display("FAIL rstmid_stale: got %0d records expected 0", obs_ts.size()); end
        if (reject_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_stale_rej: got %0d expected 0", reject_cnt); end
        tr_w = '{4}; tr_g = '{5};
        play_train(20);
        checks++;
        if (obs_ts.size() != 1 || obs_ts[0] != exp_ts[0] || obs_w[0] != 4) begin
            errors++; $display("FAIL rstmid_new: got %0d records expected 1", obs_ts.size());
        end
    endtask

    task automatic test_wrap();
        bit found = 1'b0;
        clear_q();
        for (int t = 0; t < 600 && !found; t++) begin
            step(); pulse8 = 1'b0;
            if (((cyc + S - e0) % 256) == 255) found = 1'b1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL wrap_align: got 0 expected 1"); end
        pulse8 = 1'b1;
        for (int k = 1; k < 40; k++) begin step(); pulse8 = (k < 4); end
        step(); pulse8 = 1'b1;
        repeat (3) step();
        repeat (20) begin step(); pulse8 = 1'b0; end
        checks += 2;
        if (obs8_ts.size() != 2) begin errors++; $display("FAIL wrap_count: got %0d expected 2", obs8_ts.size()); end
        else begin
            if (obs8_ts[0] != 255) begin errors++; $display("FAIL wrap_ts0: got %0d expected 255", obs8_ts[0]); end
            if (obs8_ts[1] != 39) begin errors++; $display("FAIL wrap_ts1: got %0d expected 39", obs8_ts[1]); end
        end
    endtask

    task automatic test_random();
        clear_q();
        for (int i = 0; i < 80; i++) begin
            tr_w.push_back($urandom_range(1, 6));
            tr_g.push_back($urandom_range(2, 25));
        end
        rand_ready = 1'b1;
        play_train(40);
        rand_ready = 1'b0;
        rec_ready = 1'b1;
        repeat (10) step();
        checks += 2;
        if (obs_ts.size() != exp_ts.size()) begin
            errors++; $display("FAIL rand_count: got %0d expected %0d", obs_ts.size(), exp_ts.size());
        end
        for (int i = 0; i < obs_ts.size() && i < exp_ts.size(); i++) begin
            checks++;
            if (obs_ts[i] != exp_ts[i] || obs_w[i] != exp_w[i]) begin
                errors++; $display("FAIL rand_rec%0d: got ts %0d w %0d expected ts %0d w %0d", i, obs_ts[i], obs_w[i], exp_ts[i], exp_w[i]);
            end
        end
        if (int'(reject_cnt) != rej_exp) begin errors++; $display("FAIL rand_reject: got %0d expected %0d", reject_cnt, rej_exp); end
    endtask

    initial begin
        test_reset();
        test_single_pulse();
        test_glitch();
        test_spacing();
        test_overflow();
        test_enable_drop();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
